// File: rtl/shift_arb_ctrl.sv
// Shared 16-bit shift-left / rotate-left engine, one bit position per clock,
// fronted by a two-client round-robin arbiter with registered gnt/done pulses.
module shift_arb_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] src0,
  input  logic [15:0] src1,
  input  logic [3:0]  amt0,
  input  logic [3:0]  amt1,
  input  logic        rot0,
  input  logic        rot1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] res,
  output logic        busy
);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e      state_q, state_d;
  logic [15:0] work_q, work_d;
  logic [15:0] res_q, res_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_rot_q, op_rot_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        win;

  always_comb begin
    // Round-robin only breaks ties; a lone requester always wins.
    win      = (req0 & req1) ? ~last_q : req1;
    state_d  = state_q;
    work_d   = work_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    op_rot_d = op_rot_q;
    owner_d  = owner_q;
    last_d   = last_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          work_d   = win ? src1 : src0;
          cnt_d    = win ? amt1 : amt0;
          op_rot_d = win ? rot1 : rot0;
          owner_d  = win;
          last_d   = win;
          gnt0_d   = ~win;
          gnt1_d   = win;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != 4'd0) begin
          // Rotate feeds the MSB back in; logical shift fills with zero.
          work_d = {work_q[14:0], op_rot_q & work_q[15]};
          cnt_d  = cnt_q - 4'd1;
        end else begin
          res_d   = work_q;
          done0_d = ~owner_q;
          done1_d = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      work_q   <= 16'h0000;
      res_q    <= 16'h0000;
      cnt_q    <= 4'd0;
      op_rot_q <= 1'b0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      op_rot_q <= op_rot_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign res   = res_q;
  assign busy  = (state_q == SHIFT);

endmodule
